// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: operand bypass, load-use stall, flush/hold/bubble sequencing.
// Optional macro ILLEGAL_TRAP_EN turns illegal encodings into valid trap-flagged EX entries.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    output logic [AW-1:0]   rf_a1,
    output logic [AW-1:0]   rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            stall_o,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [AW-1:0] rs1, rs2, rd;
    logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[31:25];
    assign rs1    = id_instr[15 +: AW];
    assign rs2    = id_instr[20 +: AW];
    assign rd     = id_instr[7 +: AW];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
    assign imm_u = {id_instr[31:12], 12'b0};
    assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};

    logic        legal, uses_rs1, uses_rs2;
    logic        reg_write, mem_read, mem_write, branch, jump, alu_src;
    alu_op_e     alu_op;
    logic [31:0] imm32;

    // Main decoder; legal flags OP/OP-IMM funct3/funct7 combinations outside RV32I.
    always_comb begin
        legal     = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        imm32     = 32'd0;
        case (opcode)
            OPC_LUI: begin
                legal = 1'b1; uses_rs1 = 1'b0; reg_write = 1'b1;
                alu_src = 1'b1; alu_op = ALU_PASSB; imm32 = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1; uses_rs1 = 1'b0; reg_write = 1'b1;
                alu_src = 1'b1; imm32 = imm_u;
            end
            OPC_JAL: begin
                legal = 1'b1; uses_rs1 = 1'b0; reg_write = 1'b1;
                jump = 1'b1; alu_src = 1'b1; imm32 = imm_j;
            end
            OPC_JALR: begin
                legal = 1'b1; reg_write = 1'b1; jump = 1'b1;
                alu_src = 1'b1; imm32 = imm_i;
            end
            OPC_BRANCH: begin
                legal = 1'b1; uses_rs2 = 1'b1; branch = 1'b1; imm32 = imm_b;
                case (funct3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                legal = 1'b1; reg_write = 1'b1; mem_read = 1'b1;
                alu_src = 1'b1; imm32 = imm_i;
            end
            OPC_STORE: begin
                legal = 1'b1; uses_rs2 = 1'b1; mem_write = 1'b1;
                alu_src = 1'b1; imm32 = imm_s;
            end
            OPC_OPIMM: begin
                reg_write = 1'b1; alu_src = 1'b1; imm32 = imm_i; legal = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b001: begin alu_op = ALU_SLL; legal = (funct7 == 7'h00); end
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: begin
                        alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                uses_rs2 = 1'b1; reg_write = 1'b1;
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && (funct3 == 3'b000 || funct3 == 3'b101));
                case (funct3)
                    3'b000: alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: ;
        endcase
    end

    // x0, x2 and x3 never change in the register file, so a writeback to them is not forwarded.
    logic            byp1, byp2;
    logic [XLEN-1:0] op1, op2;

    assign byp1 = wb_we && (wb_rd == rs1) && (rs1 != AW'(0)) && (rs1 != AW'(2)) && (rs1 != AW'(3));
    assign byp2 = wb_we && (wb_rd == rs2) && (rs2 != AW'(0)) && (rs2 != AW'(2)) && (rs2 != AW'(3));
    assign op1  = byp1 ? wb_data : rf_rd1;
    assign op2  = byp2 ? wb_data : rf_rd2;

    logic hazard;
    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

    assign stall_o = rst_n & (hazard | ex_hold) & ~flush;

    logic load_valid;
`ifdef ILLEGAL_TRAP_EN
    assign load_valid = id_valid;
`else
    assign load_valid = id_valid & legal;
`endif

    // update: the register changes this edge; capture: it takes the decoded instruction, else a bubble.
    logic update, capture;
    assign update  = flush | ~ex_hold;
    assign capture = ~flush & ~ex_hold & ~hazard & load_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_alu_op    <= 4'd0;
            ex_alu_src   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
        end else if (update) begin
            if (capture) begin
                ex_valid     <= 1'b1;
                ex_pc        <= id_pc;
                ex_rs1_val   <= op1;
                ex_rs2_val   <= op2;
                ex_imm       <= XLEN'($signed(imm32));
                ex_rs1       <= uses_rs1 ? rs1 : '0;
                ex_rs2       <= uses_rs2 ? rs2 : '0;
                ex_rd        <= (reg_write && legal) ? rd : '0;
                ex_alu_op    <= alu_op;
                ex_alu_src   <= alu_src;
                ex_mem_read  <= mem_read & legal;
                ex_mem_write <= mem_write & legal;
                ex_reg_write <= reg_write & legal;
                ex_branch    <= branch & legal;
                ex_jump      <= jump & legal;
            end else begin
                ex_valid     <= 1'b0;
                ex_pc        <= '0;
                ex_rs1_val   <= '0;
                ex_rs2_val   <= '0;
                ex_imm       <= '0;
                ex_rs1       <= '0;
                ex_rs2       <= '0;
                ex_rd        <= '0;
                ex_alu_op    <= 4'd0;
                ex_alu_src   <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_branch    <= 1'b0;
                ex_jump      <= 1'b0;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_illegal <= 1'b0;
        else if (update)
            ex_illegal <= capture & ~legal;
    end
`else
    assign ex_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: decode, bypass, load-use stall, flush, hold and illegal opcodes.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush, ex_hold, stall_o;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal;

    int nCompared = 0;
    int nMismatched = 0;

    localparam logic [31:0] ADDI_X5_X1_M3 = 32'hFFD08293;
    localparam logic [31:0] ADD_X6_X5_X7  = 32'h00728333;
    localparam logic [31:0] LW_X8_0_X4    = 32'h00022403;
    localparam logic [31:0] SUB_X9_X8_X1  = 32'h401404B3;
    localparam logic [31:0] SW_X5_8_X6    = 32'h00532423;
    localparam logic [31:0] BEQ_X1_X3_M8  = 32'hFE308CE3;
    localparam logic [31:0] LUI_X10       = 32'h12345537;
    localparam logic [31:0] BAD_OPCODE    = 32'h0000007F;
    localparam logic [31:0] BAD_FUNCT7_OP = 32'h02728333;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // Present an instruction in IF/ID on the falling edge.
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rd1, input logic [31:0] rd2);
        @(negedge clk);
        id_valid = 1'b1;
        id_instr = instr;
        id_pc    = pc;
        rf_rd1   = rd1;
        rf_rd2   = rd2;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_valid = 1'b1; id_instr = ADDI_X5_X1_M3; id_pc = 32'h40;
        rf_rd1 = 32'd7; rf_rd2 = 32'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        flush = 1'b0; ex_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if (ex_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", ex_valid); end
        nCompared++;
        if (stall_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
        nCompared++;
        if ({ex_imm, ex_rd, ex_reg_write, ex_alu_src, ex_illegal} !== 40'd0) begin
            nMismatched++; $display("[TB] FAIL reset_payload: got %h expected 0", {ex_imm, ex_rd, ex_reg_write, ex_alu_src, ex_illegal});
        end
        @(negedge clk);
        rst_n = 1'b1; ex_hold = 1'b0; id_valid = 1'b0;
    endtask

    task automatic test_addi();
        drive(ADDI_X5_X1_M3, 32'h100, 32'd10, 32'd0);
        nCompared++;
        if (rf_a1 !== 5'd1) begin nMismatched++; $display("[TB] FAIL addi_rf_a1: got %0d expected 1", rf_a1); end
        step();
        nCompared++;
        if (ex_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_valid: got %b expected 1", ex_valid); end
        nCompared++;
        if (ex_rs1_val !== 32'd10) begin nMismatched++; $display("[TB] FAIL addi_rs1_val: got %h expected a", ex_rs1_val); end
        nCompared++;
        if (ex_imm !== 32'hFFFFFFFD) begin nMismatched++; $display("[TB] FAIL addi_imm: got %h expected fffffffd", ex_imm); end
        nCompared++;
        if ({ex_alu_op, ex_alu_src, ex_reg_write} !== {4'd0, 1'b1, 1'b1}) begin
            nMismatched++; $display("[TB] FAIL addi_ctrl: got %b expected 000011", {ex_alu_op, ex_alu_src, ex_reg_write});
        end
        nCompared++;
        if (ex_rd !== 5'd5) begin nMismatched++; $display("[TB] FAIL addi_rd: got %0d expected 5", ex_rd); end
        nCompared++;
        if (ex_pc !== 32'h100) begin nMismatched++; $display("[TB] FAIL addi_pc: got %h expected 100", ex_pc); end
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        drive(ADD_X6_X5_X7, 32'h104, 32'd0, 32'h77);
        step();
        nCompared++;
        if (ex_rs1_val !== 32'h1234) begin nMismatched++; $display("[TB] FAIL byp_rs1_fwd: got %h expected 1234", ex_rs1_val); end
        nCompared++;
        if (ex_rs2_val !== 32'h77) begin nMismatched++; $display("[TB] FAIL byp_rs2_rf: got %h expected 77", ex_rs2_val); end
        nCompared++;
        if ({ex_alu_op, ex_alu_src, ex_rd} !== {4'd0, 1'b0, 5'd6}) begin
            nMismatched++; $display("[TB] FAIL byp_ctrl: got %h expected 06", {ex_alu_op, ex_alu_src, ex_rd});
        end
        wb_rd = 5'd2;
        drive(ADD_X6_X5_X7, 32'h108, 32'h55, 32'h77);
        step();
        nCompared++;
        if (ex_rs1_val !== 32'h55) begin nMismatched++; $display("[TB] FAIL byp_x2_ignored: got %h expected 55", ex_rs1_val); end
        wb_rd = 5'd7;
        drive(ADD_X6_X5_X7, 32'h10C, 32'h55, 32'h66);
        step();
        nCompared++;
        if (ex_rs2_val !== 32'h1234) begin nMismatched++; $display("[TB] FAIL byp_rs2_fwd: got %h expected 1234", ex_rs2_val); end
        wb_we = 1'b0; wb_rd = 5'd5;
        drive(ADD_X6_X5_X7, 32'h110, 32'h99, 32'h66);
        step();
        nCompared++;
        if (ex_rs1_val !== 32'h99) begin nMismatched++; $display("[TB] FAIL byp_we_low: got %h expected 99", ex_rs1_val); end
    endtask

    task automatic test_branch_lui();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
        drive(BEQ_X1_X3_M8, 32'h200, 32'h1, 32'h0);
        step();
        nCompared++;
        if (ex_imm !== 32'hFFFFFFF8) begin nMismatched++; $display("[TB] FAIL beq_imm: got %h expected fffffff8", ex_imm); end
        nCompared++;
        if ({ex_branch, ex_alu_op, ex_alu_src, ex_rd, ex_reg_write} !== {1'b1, 4'd1, 1'b0, 5'd0, 1'b0}) begin
            nMismatched++; $display("[TB] FAIL beq_ctrl: got %b expected 1000100000000", {ex_branch, ex_alu_op, ex_alu_src, ex_rd, ex_reg_write});
        end
        nCompared++;
        if (ex_rs2_val !== 32'h0) begin nMismatched++; $display("[TB] FAIL beq_x3_no_fwd: got %h expected 0", ex_rs2_val); end
        wb_we = 1'b0;
        drive(LUI_X10, 32'h204, 32'h0, 32'h0);
        step();
        nCompared++;
        if ({ex_imm, ex_alu_op, ex_alu_src, ex_rd, ex_rs1} !== {32'h12345000, 4'd10, 1'b1, 5'd10, 5'd0}) begin
            nMismatched++; $display("[TB] FAIL lui_decode: got %h expected %h", {ex_imm, ex_alu_op, ex_alu_src, ex_rd, ex_rs1},
                                    {32'h12345000, 4'd10, 1'b1, 5'd10, 5'd0});
        end
    endtask

    task automatic test_load_use();
        wb_we = 1'b0;
        drive(LW_X8_0_X4, 32'h300, 32'h1000, 32'h0);
        step();
        nCompared++;
        if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd8}) begin
            nMismatched++; $display("[TB] FAIL lw_in_ex: got %b expected 1101000", {ex_valid, ex_mem_read, ex_rd});
        end
        drive(SUB_X9_X8_X1, 32'h304, 32'h0, 32'h5);
        nCompared++;
        if (stall_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL lu_stall: got %b expected 1", stall_o); end
        step();
        nCompared++;
        if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin
            nMismatched++; $display("[TB] FAIL lu_bubble: got %b expected 000", {ex_valid, ex_reg_write, ex_mem_read});
        end
        wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'hCAFE;
        drive(SUB_X9_X8_X1, 32'h304, 32'h0, 32'h5);
        nCompared++;
        if (stall_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL lu_stall_release: got %b expected 0", stall_o); end
        step();
        nCompared++;
        if ({ex_valid, ex_rs1_val, ex_rs2_val} !== {1'b1, 32'hCAFE, 32'h5}) begin
            nMismatched++; $display("[TB] FAIL lu_redecode: got %h expected %h", {ex_valid, ex_rs1_val, ex_rs2_val}, {1'b1, 32'hCAFE, 32'h5});
        end
        nCompared++;
        if ({ex_alu_op, ex_rd, ex_pc} !== {4'd1, 5'd9, 32'h304}) begin
            nMismatched++; $display("[TB] FAIL lu_redecode_ctrl: got %h expected %h", {ex_alu_op, ex_rd, ex_pc}, {4'd1, 5'd9, 32'h304});
        end
        wb_we = 1'b0;
    endtask

    task automatic test_flush_hazard();
        drive(LW_X8_0_X4, 32'h400, 32'h1000, 32'h0);
        step();
        flush = 1'b1;
        drive(SUB_X9_X8_X1, 32'h404, 32'h0, 32'h5);
        nCompared++;
        if (stall_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_stall: got %b expected 0", stall_o); end
        step();
        nCompared++;
        if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) begin
            nMismatched++; $display("[TB] FAIL flush_kill: got %b expected 000", {ex_valid, ex_mem_read, ex_reg_write});
        end
        flush = 1'b0;
        drive(SUB_X9_X8_X1, 32'h500, 32'h11, 32'h5);
        nCompared++;
        if (stall_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_no_restall: got %b expected 0", stall_o); end
        step();
        nCompared++;
        if ({ex_valid, ex_rd, ex_rs1_val} !== {1'b1, 5'd9, 32'h11}) begin
            nMismatched++; $display("[TB] FAIL flush_no_bubble: got %h expected %h", {ex_valid, ex_rd, ex_rs1_val}, {1'b1, 5'd9, 32'h11});
        end
    endtask

    task automatic test_hold();
        drive(SW_X5_8_X6, 32'h600, 32'h2000, 32'hAB);
        step();
        nCompared++;
        if ({ex_valid, ex_mem_write, ex_alu_src, ex_rd, ex_imm, ex_rs1_val, ex_rs2_val} !==
            {1'b1, 1'b1, 1'b1, 5'd0, 32'd8, 32'h2000, 32'hAB}) begin
            nMismatched++; $display("[TB] FAIL sw_decode: got %h expected %h",
                {ex_valid, ex_mem_write, ex_alu_src, ex_rd, ex_imm, ex_rs1_val, ex_rs2_val},
                {1'b1, 1'b1, 1'b1, 5'd0, 32'd8, 32'h2000, 32'hAB});
        end
        for (int i = 0; i < 3; i++) begin
            ex_hold = 1'b1;
            drive(ADDI_X5_X1_M3, 32'h604, 32'h3 + i, 32'h4);
            nCompared++;
            if (stall_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_stall_%0d: got %b expected 1", i, stall_o); end
            step();
            nCompared++;
            if ({ex_valid, ex_mem_write, ex_rd, ex_imm, ex_rs2_val, ex_pc} !== {1'b1, 1'b1, 5'd0, 32'd8, 32'hAB, 32'h600}) begin
                nMismatched++; $display("[TB] FAIL hold_stable_%0d: got %h expected %h", i,
                    {ex_valid, ex_mem_write, ex_rd, ex_imm, ex_rs2_val, ex_pc}, {1'b1, 1'b1, 5'd0, 32'd8, 32'hAB, 32'h600});
            end
        end
        ex_hold = 1'b0;
        drive(ADDI_X5_X1_M3, 32'h604, 32'h20, 32'h4);
        step();
        nCompared++;
        if ({ex_valid, ex_mem_write, ex_rd, ex_imm, ex_rs1_val, ex_pc} !== {1'b1, 1'b0, 5'd5, 32'hFFFFFFFD, 32'h20, 32'h604}) begin
            nMismatched++; $display("[TB] FAIL hold_release: got %h expected %h",
                {ex_valid, ex_mem_write, ex_rd, ex_imm, ex_rs1_val, ex_pc}, {1'b1, 1'b0, 5'd5, 32'hFFFFFFFD, 32'h20, 32'h604});
        end
    endtask

    task automatic test_illegal();
        logic [31:0] badList [2];
        logic        expValid, expIllegal;
        badList[0] = BAD_OPCODE;
        badList[1] = BAD_FUNCT7_OP;
`ifdef ILLEGAL_TRAP_EN
        expValid = 1'b1; expIllegal = 1'b1;
`else
        expValid = 1'b0; expIllegal = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            drive(badList[i], 32'h700 + 32'(4 * i), 32'h1, 32'h2);
            step();
            nCompared++;
            if ({ex_valid, ex_illegal} !== {expValid, expIllegal}) begin
                nMismatched++; $display("[TB] FAIL illegal_flag_%0d: got %b expected %b", i, {ex_valid, ex_illegal}, {expValid, expIllegal});
            end
            nCompared++;
            if ({ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_rd} !== 10'd0) begin
                nMismatched++; $display("[TB] FAIL illegal_ctrl_%0d: got %b expected 0", i,
                    {ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_rd});
            end
        end
        @(negedge clk);
        id_valid = 1'b0;
        step();
        nCompared++;
        if ({ex_valid, ex_illegal} !== 2'b00) begin
            nMismatched++; $display("[TB] FAIL idle_bubble: got %b expected 00", {ex_valid, ex_illegal});
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_branch_lui();
        test_load_use();
        test_flush_hazard();
        test_hold();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the pipelined RV32I core.
- Drives the register-file read addresses and consumes the read data.
- Bypasses a same-cycle writeback, detects load-use hazards, and registers operands, immediate and control for EX.
- Handles stall, bubble and flush sequencing between IF/ID and EX.

Parameters:
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  32  instruction word.
- id_pc  in  XLEN  instruction PC.
- rf_a1  out  AW  register-file read address 1 (instr[19:15]).
- rf_a2  out  AW  register-file read address 2 (instr[24:20]).
- rf_rd1  in  XLEN  read data 1.
- rf_rd2  in  XLEN  read data 2.
- wb_we  in  1  writeback write enable.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- flush  in  1  branch/jump redirect; kill the decoding instruction.
- ex_hold  in  1  EX cannot accept; freeze the ID/EX register.
- stall_o  out  1  hold IF/ID and PC this cycle.
- ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  1/XLEN/XLEN/XLEN/XLEN  registered EX payload.
- ex_rs1, ex_rs2, ex_rd  out  AW each  registered register indices.
- ex_alu_op  out  4  ALU code: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump  out  1 each  registered control.
- ex_illegal  out  1  illegal-instruction flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): every ex_* output is 0. stall_o is 0 while reset is asserted.
- Register file:
  - Its reads are combinational; its writes take effect at the next edge.
  - x0, x2 and x3 are hardwired to zero in the register file.
- Bypass (combinational, per operand):
  - Condition: wb_we=1, wb_rd equals rs, and rs is not 0, 2 or 3.
  - When the condition holds, the operand is wb_data; otherwise it is rf_rdN.
- Decode:
  - Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediate formats I/S/B/U/J, sign-extended to XLEN.
  - uses_rs1 is 0 for LUI, AUIPC and JAL.
  - uses_rs2 is 1 only for OP, STORE and BRANCH.
  - ex_rd is forced to 0 when reg_write=0.
- Load-use hazard (combinational): hazard is asserted when all of the following hold:
  - id_valid and ex_valid are both 1, ex_mem_read=1, and ex_rd≠0.
  - ex_rd matches an operand actually used: (uses_rs1 and ex_rd==rs1) or (uses_rs2 and ex_rd==rs2).
- stall_o = (hazard | ex_hold) & ~flush.
- ID/EX update priority per edge:
  1. flush: ex_valid←0, all control←0.
  2. ex_hold: all ex_* hold their current values.
  3. hazard: insert a bubble (ex_valid←0, control←0); IF/ID is held by stall_o.
  4. Otherwise: load the decoded instruction; ex_valid←id_valid; control is zeroed if id_valid=0.
- Latency: one cycle from IF/ID to ex_*.
- Load-use penalty: exactly one bubble. The re-decode in the next cycle picks up the load result via bypass.
- flush together with hazard or ex_hold: flush wins, and stall_o=0.
- Unknown opcode without the feature: treated as a bubble (ex_valid←0).

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode, or an invalid funct3/funct7 for OP/OP-IMM, loads ex_valid=1 and ex_illegal=1.
  - ex_mem_read, ex_mem_write, ex_reg_write, ex_branch and ex_jump are forced to 0 for that instruction.
  - ex_illegal obeys the same flush/hold/bubble rules as the rest of the payload.
- Undefined: ex_illegal is tied to 0, and illegal instructions become bubbles.

Test Plan:
- Reset then decode `addi x5,x1,-3` with x1=10 → next cycle: ex_valid=1, ex_rs1_val=10, ex_imm=0xFFFFFFFD, ex_alu_op=0, ex_alu_src=1, ex_rd=5.
- `add x6,x5,x7` with wb_we=1, wb_rd=5, wb_data=0x1234 and rf_rd1=0 → ex_rs1_val=0x1234. Repeat with wb_rd=2 → ex_rs1_val=rf_rd1.
- `lw x8,0(x4)` in EX, `sub x9,x8,x1` in ID → stall_o=1 for one cycle and a bubble enters EX. The next cycle loads the sub with the bypassed x8 value.
- Hazard in the same cycle as flush=1 → stall_o=0, ex_valid=0 next cycle, and no extra bubble in the following cycle.
- ex_hold=1 for 3 cycles while a valid `sw` is in EX → all ex_* stable and stall_o=1 throughout. Release → the next instruction loads.
- Opcode 0x7F: with ILLEGAL_TRAP_EN → ex_valid=1, ex_illegal=1, all side-effect controls 0. Without the macro → ex_valid=0.
